// File: rtl/fizzbuzz_pkg.sv
// fizzbuzz_pkg: shared FSM states, ASCII constants and the word string ROM
package fizzbuzz_pkg;
  typedef enum logic [2:0] {IDLE, CONV, EMIT_WORD, EMIT_NUM, EMIT_NL} state_t;
  typedef enum logic [1:0] {W_FIZZ, W_BUZZ, W_FB} word_t;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_NL = 8'h0A;
  localparam logic [3:0] LEN_FIZZ = 4'd4;
  localparam logic [3:0] LEN_BUZZ = 4'd4;
  localparam logic [3:0] LEN_FB = 4'd8;
  // "Fizz" is bytes 0..3 and "Buzz" bytes 4..7 of the same ROM
  localparam logic [63:0] WORD_ROM = "FizzBuzz";
  function automatic logic [3:0] word_len(word_t w);
    return w == W_FB ? LEN_FB : w == W_BUZZ ? LEN_BUZZ : LEN_FIZZ;
  endfunction
  function automatic logic [7:0] word_char(word_t w, logic [2:0] i);
    logic [2:0] k;
    k = w == W_BUZZ ? i + 3'd4 : i;
    return WORD_ROM[8*(7-k) +: 8];
  endfunction
endpackage

// File: rtl/fizzbuzz_ascii_tx_if.sv
// fizzbuzz_ascii_tx_if: token input and ASCII byte output handshakes
// slave: the serialiser; master: the upstream counter plus byte sink
interface fizzbuzz_ascii_tx_if #(parameter int CW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          in_fizz;
  logic          in_buzz;
  logic          in_fizzbuzz;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic          drop;
  modport slave (
    input  in_valid, in_count, in_fizz, in_buzz, in_fizzbuzz, out_ready,
    output in_ready, out_valid, out_data, out_last, drop
  );
  modport master (
    output in_valid, in_count, in_fizz, in_buzz, in_fizzbuzz, out_ready,
    input  in_ready, out_valid, out_data, out_last, drop
  );
endinterface

// File: rtl/fizzbuzz_bcd_conv.sv
// fizzbuzz_bcd_conv: sequential double-dabble binary to BCD converter
// start/value load a conversion; done pulses CW cycles later with bcd final
module fizzbuzz_bcd_conv #(
  parameter int CW = 8,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [CW-1:0]     value,
  output logic              done,
  output logic [NDIG*4-1:0] bcd
);
  localparam int NW = $clog2(CW + 1);
  logic [CW-1:0] bin;
  logic [NW-1:0] cnt;
  logic [NDIG*4-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG; i++)
      if (bcd[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end
  // the load performs the first shift (adjusting an all-zero BCD is a no-op),
  // so the start cycle counts as the first of the CW conversion cycles
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd <= {{(NDIG*4-1){1'b0}}, value[CW-1]};
        bin <= value << 1;
        cnt <= NW'(CW - 1);
      end else if (cnt != '0) begin
        {bcd, bin} <= {adj[NDIG*4-2:0], bin, 1'b0};
        cnt <= cnt - NW'(1);
        done <= cnt == NW'(1);
      end
    end
endmodule

// File: rtl/fizzbuzz_ascii_tx.sv
// fizzbuzz_ascii_tx: serialises FizzBuzz tokens into a newline-terminated ASCII byte stream
// clk/resetn: clock, async active-low reset; bus.in_*: token handshake;
// bus.out_*: byte handshake (out_last on the newline); bus.drop: refused-offer pulse
module fizzbuzz_ascii_tx
  import fizzbuzz_pkg::*;
#(
  parameter int MAX_CYCLES = 100,
  parameter int NDIG = 3
) (
  input logic clk,
  input logic resetn,
  fizzbuzz_ascii_tx_if.slave bus
);
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam int DW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (10**NDIG <= 2**CW - 1) begin : g_ndig_check
    $error("NDIG too small for the count width");
  end
  state_t state, state_n;
  word_t word;
  logic [2:0] idx;
  logic [DW-1:0] dp, top;
  logic [NDIG*4-1:0] bcd;
  logic done, cap, num, hs, word_end;
  assign cap = bus.in_valid && bus.in_ready;
  assign num = !(bus.in_fizz || bus.in_buzz || bus.in_fizzbuzz);
  assign hs = bus.out_valid && bus.out_ready;
  assign word_end = {1'b0, idx} == word_len(word) - 4'd1;
  fizzbuzz_bcd_conv #(.CW(CW), .NDIG(NDIG)) u_conv (
    .clk,
    .resetn,
    .start(cap && num),
    .value(bus.in_count),
    .done,
    .bcd
  );
  // most significant non-zero digit; zero falls back to digit 0 so "0" is emitted
  always_comb begin
    top = '0;
    for (int i = 1; i < NDIG; i++)
      if (bcd[4*i +: 4] != 4'd0) top = DW'(i);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = cap ? (num ? CONV : EMIT_WORD) : IDLE;
      CONV:      state_n = done ? EMIT_NUM : CONV;
      EMIT_WORD: state_n = hs && word_end ? EMIT_NL : EMIT_WORD;
      EMIT_NUM:  state_n = hs && dp == '0 ? EMIT_NL : EMIT_NUM;
      EMIT_NL:   state_n = hs ? IDLE : EMIT_NL;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state inside {EMIT_WORD, EMIT_NUM, EMIT_NL};
    bus.out_last  = state == EMIT_NL;
    bus.out_data  = state == EMIT_WORD ? word_char(word, idx) :
                    state == EMIT_NUM  ? ASCII_0 + {4'd0, bcd[4*dp +: 4]} :
                    state == EMIT_NL   ? ASCII_NL : 8'h00;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      word     <= W_FIZZ;
      idx      <= '0;
      dp       <= '0;
      bus.drop <= 1'b0;
    end else begin
      bus.drop <= bus.in_valid && !bus.in_ready;
      if (cap) begin
        word <= bus.in_fizzbuzz ? W_FB : bus.in_fizz ? W_FIZZ : W_BUZZ;
        idx  <= '0;
      end else if (state == EMIT_WORD && hs) idx <= idx + 3'd1;
      if (state == CONV && done) dp <= top;
      else if (state == EMIT_NUM && hs) dp <= dp - DW'(1);
    end
endmodule

// File: tb/tb_fizzbuzz_ascii_tx.sv
// tb_fizzbuzz_ascii_tx: scoreboard bench for the FizzBuzz ASCII serialiser
module tb_fizzbuzz_ascii_tx;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  fizzbuzz_ascii_tx_if #(.CW(8)) bus();
  fizzbuzz_ascii_tx #(.MAX_CYCLES(100), .NDIG(3)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int drop_cnt = 0;
  int rdy_mode = 0;
  int pat_i = 0;
  logic [8:0] exp_q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic expect_tok(input int c, input bit f, input bit b, input bit fb);
    string s;
    if (fb) s = "FizzBuzz";
    else if (f) s = "Fizz";
    else if (b) s = "Buzz";
    else s = $sformatf("%0d", c);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b0, s[i]});
    exp_q.push_back({1'b1, 8'h0A});
  endtask
  task automatic send(input int c, input bit f, input bit b, input bit fb, output int lat);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_wait", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_count = 8'(c);
    bus.in_fizz = f;
    bus.in_buzz = b;
    bus.in_fizzbuzz = fb;
    @(posedge clk);
    expect_tok(c, f, b, fb);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 1);
  endtask
  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) bus.out_ready = 1'b1;
      else if (rdy_mode == 1) begin
        bus.out_ready = pat[pat_i % 4];
        pat_i++;
      end else bus.out_ready = 1'($urandom_range(0, 1));
    end
  end
  initial begin
    bit prev_stall, prev_off, pl;
    logic [7:0] pd;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_off = 1'b0;
    pl = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stall = 1'b0;
        prev_off = 1'b0;
      end else begin
        chk("drop", 32'(bus.drop), 32'(prev_off));
        if (bus.drop) drop_cnt++;
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.out_valid), 1);
          chk("stall_data", 32'(bus.out_data), 32'(pd));
          chk("stall_last", 32'(bus.out_last), 32'(pl));
        end
        if (bus.out_valid && bus.out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) chk("extra_byte", 32'(bus.out_data), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("byte", 32'(bus.out_data), 32'(e[7:0]));
            chk("last", 32'(bus.out_last), 32'(e[8]));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        pd = bus.out_data;
        pl = bus.out_last;
        prev_off = bus.in_valid && !bus.in_ready;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, c, d0, h0, k;
    bit f, b, fb, rdy, got;
    bus.in_valid = 1'b0;
    bus.in_count = 8'd0;
    bus.in_fizz = 1'b0;
    bus.in_buzz = 1'b0;
    bus.in_fizzbuzz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_drop", 32'(bus.drop), 0);
    @(posedge clk); #1 resetn = 1'b1;
    send(0, 1, 1, 1, lat);
    chk("t1_latency", lat, 1);
    k = 0;
    while (!(bus.out_valid && bus.out_last && bus.out_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t1_ready_at_nl", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("t1_ready_after_nl", 32'(bus.in_ready), 1);
    wait_idle("t1");
    send(7, 0, 0, 0, lat);
    chk("t2_latency", lat, 9);
    wait_idle("t2");
    pat_i = 0;
    rdy_mode = 1;
    send(98, 0, 0, 0, lat);
    chk("t3_latency", lat, 9);
    wait_idle("t3");
    rdy_mode = 0;
    send(3, 1, 0, 0, lat);
    d0 = drop_cnt;
    c = 20;
    got = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 50 && !got; i++) begin
      f = c % 3 == 0;
      b = c % 5 == 0;
      bus.in_valid = 1'b1;
      bus.in_count = 8'(c);
      bus.in_fizz = f;
      bus.in_buzz = b;
      bus.in_fizzbuzz = f && b;
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        expect_tok(c, f, b, f && b);
        got = 1'b1;
      end
      #1;
      if (!got) c++;
    end
    bus.in_valid = 1'b0;
    chk("t4_captured", 32'(got), 1);
    chk("t4_value", c, 24);
    wait_idle("t4");
    chk("t4_drops", drop_cnt - d0, 4);
    h0 = hs_cnt;
    send(6, 1, 0, 0, lat);
    k = 0;
    while (hs_cnt < h0 + 3 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t5_progress", hs_cnt - h0, 3);
    @(posedge clk); #2 resetn = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 0);
    chk("t5_rst_last", 32'(bus.out_last), 0);
    chk("t5_rst_ready", 32'(bus.in_ready), 1);
    chk("t5_rst_data", 32'(bus.out_data), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    send(5, 0, 1, 0, lat);
    chk("t5_latency", lat, 1);
    wait_idle("t5");
    d0 = drop_cnt;
    for (int n = 0; n < 100; n++) begin
      f = n % 3 == 0;
      b = n % 5 == 0;
      send(n, f, b, f && b, lat);
      chk("t6_latency", lat, (f || b) ? 1 : 9);
      wait_idle("t6");
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    chk("t6_drops", drop_cnt - d0, 0);
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 255);
      f = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      fb = 1'($urandom_range(0, 1));
      send(c, f, b, fb, lat);
      chk("rnd_latency", lat, (f || b || fb) ? 1 : 9);
    end
    wait_idle("rnd");
    rdy_mode = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
